// File: rtl/single_readout_if.sv
// Output beat link of the single-stub readout: 16-bit beats moved on out_valid & out_ready.
interface single_readout_if;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/single_readout.sv
// Single-stub readout: BX stamping, FIFO buffering, 3-beat serializer, saturating drop counter.
// Optional per-orbit rate limit is enabled with `define SINGLE_RATE_LIMIT_EN.
module single_readout #(
  parameter int BW_FPH        = 13,
  parameter int BW_TH         = 7,
  parameter int FIFO_DEPTH    = 8,
  parameter int ORBIT_LEN     = 3564,
  parameter int MAX_PER_ORBIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vl_single,
  input  logic [BW_FPH-1:0]   ph_single,
  input  logic [BW_TH-1:0]    th_single,
  input  logic                bc0,
  single_readout_if.master    out_if,
  output logic [15:0]         drop_cnt,
  output logic                fifo_full,
  output logic [1:0]          fsm_state
);
  // Handshake: a beat transfers on a clock edge where out_valid & out_ready are both high;
  // while out_valid is high and out_ready low, out_data holds its value.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 12 + BW_FPH + BW_TH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PH   = 2'd2;
  localparam logic [1:0] S_TH   = 2'd3;

  logic [11:0]       bxc_q, bxc_d, bx_stamp;
  logic              in_vl_q;
  logic [BW_FPH-1:0] in_ph_q;
  logic [BW_TH-1:0]  in_th_q;
  logic [11:0]       in_bx_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, empty;
  logic              push, pop, drop, rate_ok, hs;
  logic [1:0]        state_q, state_d;
  logic [EW-1:0]     lat_q;
  logic [15:0]       drop_cnt_q;

  always_comb begin
    bx_stamp = bc0 ? 12'd0 : bxc_q;
    if (bc0)                              bxc_d = 12'd1;
    else if (bxc_q == 12'(ORBIT_LEN - 1)) bxc_d = 12'd0;
    else                                  bxc_d = bxc_q + 12'd1;
  end

`ifdef SINGLE_RATE_LIMIT_EN
  logic [15:0] orb_cnt_q, orb_cnt_d, orb_base;
  // A zero stamp opens a new orbit and that stub already counts in it.
  always_comb begin
    orb_base  = (in_bx_q == 12'd0) ? 16'd0 : orb_cnt_q;
    rate_ok   = (orb_base < 16'(MAX_PER_ORBIT));
    orb_cnt_d = orb_base + {15'd0, push};
  end

  always_ff @(posedge clk) begin
    if (rst) orb_cnt_q <= 16'd0;
    else     orb_cnt_q <= orb_cnt_d;
  end
`else
  assign rate_ok = 1'b1;
`endif

  // Full comes from the start-of-cycle register, so a same-cycle pop never rescues a push.
  assign empty = (cnt_q == '0);
  assign push  = in_vl_q & ~full_q & rate_ok;
  assign drop  = in_vl_q & ~push;
  assign hs    = out_if.out_valid & out_if.out_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin pop = 1'b1; state_d = S_HDR; end
      S_HDR:  if (hs) state_d = S_PH;
      S_PH:   if (hs) state_d = S_TH;
      S_TH:   if (hs) begin
                if (!empty) begin pop = 1'b1; state_d = S_HDR; end
                else        state_d = S_IDLE;
              end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_bx_q, in_ph_q, in_th_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bxc_q      <= 12'd0;
      in_vl_q    <= 1'b0;
      in_ph_q    <= '0;
      in_th_q    <= '0;
      in_bx_q    <= 12'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      state_q    <= S_IDLE;
      lat_q      <= '0;
      drop_cnt_q <= 16'd0;
    end else begin
      bxc_q   <= bxc_d;
      in_vl_q <= vl_single;
      in_ph_q <= ph_single;
      in_th_q <= th_single;
      in_bx_q <= bx_stamp;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        lat_q    <= mem_q[rd_ptr_q];
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(FIFO_DEPTH));
      state_q <= state_d;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    case (state_q)
      S_HDR:   out_if.out_data = {4'hA, lat_q[EW-1 -: 12]};
      S_PH:    out_if.out_data = 16'(lat_q[BW_FPH+BW_TH-1 -: BW_FPH]);
      S_TH:    out_if.out_data = 16'(lat_q[BW_TH-1:0]);
      default: out_if.out_data = 16'd0;
    endcase
  end

  assign out_if.out_valid = (state_q != S_IDLE);
  assign drop_cnt         = drop_cnt_q;
  assign fifo_full        = full_q;
  assign fsm_state        = state_q;
endmodule
